hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Consumer-side controller for the decode→execute pipeline register. It drives that register's flushE and reads back the rs1E/rs2E/rdE/resultsrcE/pcsrcE it emits.
- Generates stall, flush and forwarding controls for the 5-stage core: F, D, E, M, W.
- Adds a sequential memory-wait FSM with a watchdog for multi-cycle data-memory accesses.
- Sits beside the pipeline registers in the core top level.

Parameters:
- REG_AW, 5: register-address width.
- TIMEOUT, 16: maximum consecutive memory-wait cycles before error.
- CNT_W, 32: performance-counter width (HAZARD_PERF_EN only).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- rs1D, rs2D  in  REG_AW  decode-stage source registers
- rs1E, rs2E, rdE  in  REG_AW  execute-stage registers, from the decode→execute register
- resultsrcE  in  2  result select; RES_MEM = 2'b01 marks a load
- pcsrcE  in  1  taken branch/jump resolved in E
- rdM, rdW  in  REG_AW  destination registers in M and W
- regwriteM, regwriteW  in  1  write enables in M and W
- memreqM  in  1  data-memory access in M
- memackM  in  1  data memory completes this cycle
- stallF, stallD, stallE, stallM  out  1  hold the stage register
- flushD, flushE, flushW  out  1  clear the stage register
- forwardAE, forwardBE  out  2  operand select: 00 regfile, 01 W result, 10 M ALU result
- mem_err  out  1  sticky watchdog error
- stall_cnt, flush_cnt  out  CNT_W  performance counters

Behaviour:
- Forwarding is combinational.
  - forwardAE = 10 if regwriteM, rdM≠0 and rdM==rs1E.
  - Otherwise forwardAE = 01 if regwriteW, rdW≠0 and rdW==rs1E.
  - Otherwise forwardAE = 00. M has priority over W.
  - forwardBE follows the same rule using rs2E.
- lwstall = (resultsrcE==RES_MEM) and rdE≠0 and (rdE==rs1D or rdE==rs2D).
- memstall = memreqM and not memackM.
- FSM states: RUN, MEMWAIT, ERROR. State is updated on posedge clk.
  - RUN → MEMWAIT when memstall. The wait counter loads 1.
  - MEMWAIT, memackM: go to RUN; counter clears.
  - MEMWAIT, no memackM: counter increments. When the counter reaches TIMEOUT, go to ERROR.
  - ERROR → ERROR until reset. mem_err=1 in ERROR.
- Outputs are Mealy. Evaluate in priority order:
  1. State ERROR, or memstall (any state): stallF=stallD=stallE=stallM=1, flushW=1, flushD=flushE=0. A pending pcsrcE is held in E and takes effect once the stall clears.
  2. pcsrcE: flushD=flushE=1, stallF=stallD=0. The branch overrides a simultaneous lwstall, because the load-use consumer is wrong-path.
  3. lwstall: stallF=stallD=1, flushE=1. This inserts exactly one bubble.
  4. Otherwise: all stall and flush outputs are 0.
- A request acked in the same cycle (memreqM=memackM=1) causes no stall and leaves the state unchanged.
- Reset, asynchronous and at any time including mid-MEMWAIT:
  - State goes to RUN; counters and mem_err go to 0.
  - While rst_n=0: flushD=flushE=flushW=1, all stalls 0, forwardAE=forwardBE=00.
- stallM and flushW are never asserted together except in case 1 above.

Optional Feature:
- HAZARD_PERF_EN defined:
  - stall_cnt increments each cycle any stall output is 1.
  - flush_cnt increments each cycle flushD or flushE is 1, excluding reset.
  - Both counters saturate at all-ones.
- HAZARD_PERF_EN undefined: stall_cnt and flush_cnt are tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package: RES_MEM and the other resultsrc encodings, the FWD_REG/FWD_W/FWD_M enum, and the hzd_state_t enum.
- Sub-module hazard_fwd_sel holds the combinational forwarding compare. It is instantiated twice, once for operand A and once for operand B.
- The FSM, watchdog and counters live in the top module.

Test Plan:
- Forwarding: rs1E=5, rdM=5, regwriteM=1, rdW=5, regwriteW=1 → forwardAE=10. Then rdM=0 → forwardAE=01.
- Load-use: resultsrcE=01, rdE=3, rs2D=3 → one cycle of stallF=stallD=flushE=1, then all zero.
- Branch and load together: pcsrcE=1 with lwstall true → flushD=flushE=1, stallF=0.
- Memory wait: memreqM=1, memackM low for 3 cycles then high → stalls and flushW=1 for exactly 3 cycles; FSM back in RUN.
- Watchdog: memreqM=1, memackM=0 held for TIMEOUT=16 cycles → mem_err=1 from cycle 17 with stalls stuck. Assert rst_n=0 mid-error → mem_err=0 immediately, flushes=1.
- Performance counters (HAZARD_PERF_EN): run the load-use plus branch sequence → stall_cnt=1, flush_cnt=2.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard controller: result-source selects,
// forwarding selects, memory-wait FSM states and the stall/flush bundle.
package hazard_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01,
    ERROR   = 2'b10
  } hzd_state_t;

  typedef struct packed {
    logic stallF;
    logic stallD;
    logic stallE;
    logic stallM;
    logic flushD;
    logic flushE;
    logic flushW;
  } hzd_ctl_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand forwarding select for one execute-stage source register.
// The M-stage ALU result wins over the W-stage result; x0 is never forwarded.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rdM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              regwriteM,
  input  logic              regwriteW,
  output fwd_sel_t          fwd
);

  always_comb begin
    fwd = FWD_REG;
    if (regwriteM && (rdM != '0) && (rdM == rsE))
      fwd = FWD_M;
    else if (regwriteW && (rdW != '0) && (rdW == rsE))
      fwd = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding control for the 5-stage core plus a memory-wait FSM
// with watchdog. Define HAZARD_PERF_EN to build the stall/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdE,
  input  logic [1:0]        resultsrcE,
  input  logic              pcsrcE,
  input  logic [REG_AW-1:0] rdM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              regwriteM,
  input  logic              regwriteW,
  input  logic              memreqM,
  input  logic              memackM,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushW,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  // Operand 0 is A (rs1E), operand 1 is B (rs2E).
  logic [1:0][REG_AW-1:0] rs_e;
  fwd_sel_t               fwd [2];

  assign rs_e = {rs2E, rs1E};

  for (genvar i = 0; i < 2; i++) begin : g_fwd
    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd (
      .rsE      (rs_e[i]),
      .rdM      (rdM),
      .rdW      (rdW),
      .regwriteM(regwriteM),
      .regwriteW(regwriteW),
      .fwd      (fwd[i])
    );
  end

  assign forwardAE = rst_n ? fwd[0] : FWD_REG;
  assign forwardBE = rst_n ? fwd[1] : FWD_REG;

  logic memstall, lwstall;

  assign memstall = memreqM && !memackM;
  assign lwstall  = (resultsrcE == RES_MEM) && (rdE != '0) &&
                    ((rdE == rs1D) || (rdE == rs2D));

  hzd_state_t        state, state_nx;
  logic [WCNT_W-1:0] wcnt, wcnt_nx;
  hzd_ctl_t          ctl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    ctl      = '0;

    case (state)
      RUN: begin
        if (memstall) begin
          state_nx = MEMWAIT;
          wcnt_nx  = WCNT_W'(1);
        end
      end
      MEMWAIT: begin
        if (memackM) begin
          state_nx = RUN;
          wcnt_nx  = '0;
        end else begin
          wcnt_nx = wcnt + WCNT_W'(1);
          if (wcnt_nx >= WCNT_W'(TIMEOUT)) state_nx = ERROR;
        end
      end
      ERROR:   state_nx = ERROR;
      default: state_nx = RUN;
    endcase

    // Branch is held in E during a memory stall and resolves once it clears.
    if (!rst_n) begin
      ctl.flushD = 1'b1;
      ctl.flushE = 1'b1;
      ctl.flushW = 1'b1;
    end else if ((state == ERROR) || memstall) begin
      ctl.stallF = 1'b1;
      ctl.stallD = 1'b1;
      ctl.stallE = 1'b1;
      ctl.stallM = 1'b1;
      ctl.flushW = 1'b1;
    end else if (pcsrcE) begin
      ctl.flushD = 1'b1;
      ctl.flushE = 1'b1;
    end else if (lwstall) begin
      ctl.stallF = 1'b1;
      ctl.stallD = 1'b1;
      ctl.flushE = 1'b1;
    end
  end

  assign stallF  = ctl.stallF;
  assign stallD  = ctl.stallD;
  assign stallE  = ctl.stallE;
  assign stallM  = ctl.stallM;
  assign flushD  = ctl.flushD;
  assign flushE  = ctl.flushE;
  assign flushW  = ctl.flushW;
  assign mem_err = (state == ERROR);

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  // Saturating; reset cycles never count since the registers are held clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if ((ctl.stallF || ctl.stallD || ctl.stallE || ctl.stallM) && !(&stall_q))
        stall_q <= stall_q + CNT_W'(1);
      if ((ctl.flushD || ctl.flushE) && !(&flush_q))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: per-cycle comparison against a behavioural model
// plus directed vectors with hand-computed expectations.
module tb_hazard_ctrl;

  localparam int REG_AW  = 5;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [REG_AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic [1:0]        resultsrcE;
  logic              pcsrcE, regwriteM, regwriteW, memreqM, memackM;
  logic              stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_err;
  logic [1:0]        forwardAE, forwardBE;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  hazard_ctrl #(.REG_AW(REG_AW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .resultsrcE(resultsrcE), .pcsrcE(pcsrcE), .rdM(rdM), .rdW(rdW),
    .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memreqM(memreqM), .memackM(memackM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit       sF, sD, sE, sM, fD, fE, fW;
    bit [1:0] fa, fb;
  } exp_t;

  int               m_wait = 0;   // cycles spent in the current memory wait
  bit               m_err  = 0;
  logic [CNT_W-1:0] m_scnt = '0;
  logic [CNT_W-1:0] m_fcnt = '0;

  function automatic bit [1:0] fwd_of(input logic [REG_AW-1:0] rs);
    if (regwriteM && rdM != 0 && rdM == rs) return 2'b10;
    if (regwriteW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t expected();
    exp_t e = '{default: 0};
    bit ms, lw;
    if (!rst_n) begin
      e.fD = 1; e.fE = 1; e.fW = 1;
      return e;
    end
    e.fa = fwd_of(rs1E);
    e.fb = fwd_of(rs2E);
    ms = memreqM && !memackM;
    lw = (resultsrcE == 2'b01) && rdE != 0 && (rdE == rs1D || rdE == rs2D);
    if (m_err || ms) begin
      e.sF = 1; e.sD = 1; e.sE = 1; e.sM = 1; e.fW = 1;
    end else if (pcsrcE) begin
      e.fD = 1; e.fE = 1;
    end else if (lw) begin
      e.sF = 1; e.sD = 1; e.fE = 1;
    end
    return e;
  endfunction

  function automatic bit any_stall();
    exp_t e = expected();
    return e.sF || e.sD || e.sE || e.sM;
  endfunction

  function automatic bit any_flush();
    exp_t e = expected();
    return e.fD || e.fE;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait <= 0;
      m_err  <= 0;
      m_scnt <= '0;
      m_fcnt <= '0;
    end else begin
      if (any_stall() && m_scnt != '1) m_scnt <= m_scnt + 1;
      if (any_flush() && m_fcnt != '1) m_fcnt <= m_fcnt + 1;
      if (!m_err) begin
        if (m_wait == 0) begin
          if (memreqM && !memackM) m_wait <= 1;
        end else if (memackM) begin
          m_wait <= 0;
        end else begin
          m_wait <= m_wait + 1;
          if (m_wait + 1 >= TIMEOUT) m_err <= 1;
        end
      end
    end
  end

  task automatic compare_all();
    exp_t e = expected();
    check("m_stallF", stallF, e.sF);
    check("m_stallD", stallD, e.sD);
    check("m_stallE", stallE, e.sE);
    check("m_stallM", stallM, e.sM);
    check("m_flushD", flushD, e.fD);
    check("m_flushE", flushE, e.fE);
    check("m_flushW", flushW, e.fW);
    check("m_fwdA", forwardAE, e.fa);
    check("m_fwdB", forwardBE, e.fb);
    check("m_memerr", mem_err, m_err);
`ifdef HAZARD_PERF_EN
    check("m_stallcnt", stall_cnt, m_scnt);
    check("m_flushcnt", flush_cnt, m_fcnt);
`else
    check("m_stallcnt", stall_cnt, 0);
    check("m_flushcnt", flush_cnt, 0);
`endif
  endtask

  always @(negedge clk) compare_all();

  // ---------------- directed stimulus ----------------
  task automatic idle();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    resultsrcE = 0; pcsrcE = 0; regwriteM = 0; regwriteW = 0;
    memreqM = 0; memackM = 0;
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    #1;
    check("rst_flushD", flushD, 1);
    check("rst_flushW", flushW, 1);
    check("rst_stallF", stallF, 0);
    check("rst_memerr", mem_err, 0);
    cyc(2);
    rst_n = 1;
    cyc();

    // forwarding priority
    rs1E = 5; rdM = 5; regwriteM = 1; rdW = 5; regwriteW = 1;
    #1 check("fwdA_M", forwardAE, 2'b10);
    rdM = 0;
    #1 check("fwdA_W", forwardAE, 2'b01);
    rs2E = 5;
    #1 check("fwdB_W", forwardBE, 2'b01);
    regwriteW = 0;
    #1 check("fwdB_none", forwardBE, 2'b00);
    cyc();
    idle();

    // load-use: one bubble
    resultsrcE = 2'b01; rdE = 3; rs2D = 3;
    #1;
    check("lw_stallF", stallF, 1);
    check("lw_stallD", stallD, 1);
    check("lw_flushE", flushE, 1);
    check("lw_stallE", stallE, 0);
    cyc();
    resultsrcE = 2'b00;
    #1;
    check("lw_after_stallF", stallF, 0);
    check("lw_after_flushE", flushE, 0);
    cyc();

    // load into x0 never stalls
    resultsrcE = 2'b01; rdE = 0; rs1D = 0;
    #1 check("lw_x0_stallF", stallF, 0);
    cyc();
    idle();

    // branch overrides load-use
    resultsrcE = 2'b01; rdE = 3; rs2D = 3; pcsrcE = 1;
    #1;
    check("br_flushD", flushD, 1);
    check("br_flushE", flushE, 1);
    check("br_stallF", stallF, 0);
    check("br_stallD", stallD, 0);
    cyc();
    idle();

    // three-cycle memory wait
    memreqM = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mw_stallM", stallM, 1);
      check("mw_flushW", flushW, 1);
      check("mw_stallF", stallF, 1);
      cyc();
    end
    memackM = 1;
    #1;
    check("mw_ack_stallM", stallM, 0);
    check("mw_ack_flushW", flushW, 0);
    cyc();
    idle();
    cyc();

    // same-cycle ack: no stall
    memreqM = 1; memackM = 1;
    #1 check("ack0_stallF", stallF, 0);
    cyc();
    idle();

    // memory stall holds a pending branch
    memreqM = 1; pcsrcE = 1;
    #1;
    check("msbr_flushD", flushD, 0);
    check("msbr_stallE", stallE, 1);
    cyc();
    memackM = 1;
    #1;
    check("msbr_rel_flushE", flushE, 1);
    check("msbr_rel_stallM", stallM, 0);
    cyc();
    idle();
    cyc();

    // watchdog
    memreqM = 1;
    for (int i = 1; i <= TIMEOUT; i++) begin
      #1 check("wd_pre_memerr", mem_err, 0);
      cyc();
    end
    #1;
    check("wd_memerr", mem_err, 1);
    check("wd_stallM", stallM, 1);
    memreqM = 0; pcsrcE = 1;
    cyc();
    check("wd_stuck_stallF", stallF, 1);
    check("wd_stuck_flushD", flushD, 0);
    rst_n = 0;
    #1;
    check("wd_rst_memerr", mem_err, 0);
    check("wd_rst_flushD", flushD, 1);
    check("wd_rst_flushE", flushE, 1);
    check("wd_rst_stallF", stallF, 0);
    idle();
    cyc(2);
    rst_n = 1;
    cyc();

    // load-use then branch for the counters
    resultsrcE = 2'b01; rdE = 3; rs1D = 3;
    cyc();
    idle();
    pcsrcE = 1;
    cyc();
    idle();
    #1;
`ifdef HAZARD_PERF_EN
    check("perf_stall_cnt", stall_cnt, 1);
    check("perf_flush_cnt", flush_cnt, 2);
`else
    check("perf_stall_cnt", stall_cnt, 0);
    check("perf_flush_cnt", flush_cnt, 0);
`endif
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
